axil_slave_arb: RTL and testbench
=================================

Name: axil_slave_arb

Overview:
- Next-generation AXI-Lite slave front-end. Converts AXI-Lite transactions into single-port user register accesses.
- Accepts AW and W independently, each into its own one-entry buffer.
- Arbitrates fairly between pending reads and writes.
- Supports user wait states through an ack handshake.
- Produces DECERR for out-of-range addresses and SLVERR for user errors or timeouts.
- Sits between the interconnect and peripheral register banks.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ADDR_BASE, 0, base address of the decoded window (aligned to 2^ADDR_SPAN_BITS).
- ADDR_SPAN_BITS, 12, log2 of window size in bytes.
- TIMEOUT, 16, maximum cycles to wait for usr_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_aw{addr,prot,valid,ready}  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel.
- s_axil_w{data,strb,valid,ready}  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel.
- s_axil_b{resp,valid,ready}  out/out/in  2/1/1  write response channel.
- s_axil_ar{addr,prot,valid,ready}  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel.
- s_axil_r{data,resp,valid,ready}  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- usr_addr  out  ADDR_WIDTH  access address, offset within the window (addr minus ADDR_BASE).
- usr_wdata  out  DATA_WIDTH  write data.
- usr_wstrb  out  STRB_WIDTH  write strobes.
- usr_wen  out  1  one-cycle write request strobe.
- usr_ren  out  1  one-cycle read request strobe.
- usr_rdata  in  DATA_WIDTH  read data, sampled when usr_ack is high.
- usr_ack  in  1  access complete; may be high in the strobe cycle or any later cycle.
- usr_err  in  1  error qualifier for usr_ack.

Behaviour:
- Reset (async assert, sync release):
  - All readys, valids, usr_wen and usr_ren are 0; bresp/rresp = 0; rdata = 0; usr_addr/wdata/wstrb = 0.
  - All buffers are emptied, FSM goes to IDLE, arbitration pointer = READ.
  - Readys stay 0 for the first cycle after release, then follow the buffer rules below.
- Buffers:
  - awready = enabled & !aw_full. Handshake at an edge sets aw_full and latches addr.
  - W and AR channels behave identically with w_full and ar_full.
  - A full buffer's contents never change until it is freed.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE arbitration:
  - Write is eligible when aw_full & w_full; read is eligible when ar_full.
  - If both are eligible, the grant goes opposite to the last grant (first tie after reset goes to write). The last grant updates on each grant.
- Decode: in range iff addr[ADDR_WIDTH-1:ADDR_SPAN_BITS] == ADDR_BASE[ADDR_WIDTH-1:ADDR_SPAN_BITS].
  - Out-of-range grant goes directly to WR_RESP/RD_RESP with resp = 2'b11 (DECERR) and rdata = 0. No usr strobe is issued.
- WR_REQ / RD_REQ:
  - usr_wen (or usr_ren) is high for exactly the first cycle in the state.
  - usr_addr/usr_wdata/usr_wstrb are held stable for the whole state; usr_addr = 0 outside REQ states.
  - usr_wen and usr_ren are never both high.
  - On usr_ack: resp = usr_err ? 2'b10 : 2'b00. For reads, rdata = usr_err ? 0 : usr_rdata.
  - Timeout counter starts at 0 on entry and increments each cycle without ack. If TIMEOUT != 0 and counter == TIMEOUT-1 with no ack: resp = 2'b10, rdata = 0.
  - Either outcome moves to the RESP state.
  - usr_ack arriving outside REQ states is ignored, including late acks after a timeout.
- WR_RESP / RD_RESP:
  - bvalid (rvalid) is high with resp and rdata stable until the ready handshake.
  - On handshake, the consumed buffers are freed (aw and w, or ar) and the FSM returns to IDLE. Readys reassert the next cycle.
- Latency with zero-wait ack:
  - Buffer handshake at edge N.
  - Strobe high in the cycle after edge N+1.
  - b/rvalid high after edge N+2.
- Back-pressure: new AW/W/AR may be buffered while another transaction is in REQ/RESP, one per channel.
- prot is accepted and ignored.
- Reset asserted mid-transaction aborts it with no response; the master must also be reset.

Test Plan:
- Write: AW 0x0000_0010 and W 0xDEADBEEF/strb 0xF in the same cycle, usr_ack in the strobe cycle -> usr_wen for 1 cycle with usr_addr 0x10, bvalid 2 cycles after handshake, bresp 00.
- Read: AR 0x0000_0004, usr_ack after 3 wait cycles with usr_rdata 0x12345678 -> usr_ren for 1 cycle, rvalid with rdata 0x12345678 and rresp 00.
- W arrives 5 cycles before AW -> wready drops after the W handshake. No usr_wen until AW is accepted, then a normal write completes.
- Simultaneous pending read and write, repeated 4 times -> grants alternate W,R,W,R, and usr_wen/usr_ren are never high together.
- Out-of-range AR 0x0000_2000 (ADDR_SPAN_BITS = 12) -> no usr_ren, rresp 11, rdata 0.
- No usr_ack for TIMEOUT = 16 cycles -> bresp 10. An ack at cycle 20 is ignored. usr_err = 1 on a read ack -> rresp 10, rdata 0. bready held low for 10 cycles -> bvalid and bresp stay stable throughout.

Source files
------------

// File: rtl/axil_slave_arb.sv
// AXI-Lite slave front-end: one-entry AW/W/AR buffers, fair read/write arbitration
// and a single-port user register interface with ack, error and timeout handling.
module axil_slave_arb #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = '0,
    parameter int                    ADDR_SPAN_BITS = 12,
    parameter int                    TIMEOUT        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wdata,
    output logic [STRB_WIDTH-1:0] usr_wstrb,
    output logic                  usr_wen,
    output logic                  usr_ren,
    input  logic [DATA_WIDTH-1:0] usr_rdata,
    input  logic                  usr_ack,
    input  logic                  usr_err
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:ADDR_SPAN_BITS] == ADDR_BASE[ADDR_WIDTH-1:ADDR_SPAN_BITS];
    endfunction

    state_t                  state_r, state_nxt_s;
    logic                    en_r, aw_full_r, w_full_r, ar_full_r, last_wr_r;
    logic [ADDR_WIDTH-1:0]   aw_addr_r, ar_addr_r, usr_addr_r;
    logic [DATA_WIDTH-1:0]   w_data_r, usr_wdata_r, rdata_r;
    logic [STRB_WIDTH-1:0]   w_strb_r, usr_wstrb_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    usr_wen_r, usr_ren_r, bvalid_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r, req_resp_s;
    logic                    grant_wr_s, grant_rd_s, req_done_s, tmo_s;
    logic                    aw_in_s, ar_in_s, wr_free_s, rd_free_s;
    logic                    aw_hs_s, w_hs_s, ar_hs_s;
    logic                    unused_s;

    assign unused_s       = ^{s_axil_awprot, s_axil_arprot};
    assign s_axil_awready = en_r & ~aw_full_r;
    assign s_axil_wready  = en_r & ~w_full_r;
    assign s_axil_arready = en_r & ~ar_full_r;
    assign aw_hs_s        = s_axil_awvalid & s_axil_awready;
    assign w_hs_s         = s_axil_wvalid & s_axil_wready;
    assign ar_hs_s        = s_axil_arvalid & s_axil_arready;
    assign aw_in_s        = in_window(aw_addr_r);
    assign ar_in_s        = in_window(ar_addr_r);
    assign wr_free_s      = (state_r == WR_RESP) & s_axil_bready;
    assign rd_free_s      = (state_r == RD_RESP) & s_axil_rready;
    assign tmo_s          = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

    assign s_axil_bvalid = bvalid_r;
    assign s_axil_bresp  = bresp_r;
    assign s_axil_rvalid = rvalid_r;
    assign s_axil_rresp  = rresp_r;
    assign s_axil_rdata  = rdata_r;
    assign usr_addr      = usr_addr_r;
    assign usr_wdata     = usr_wdata_r;
    assign usr_wstrb     = usr_wstrb_r;
    assign usr_wen       = usr_wen_r;
    assign usr_ren       = usr_ren_r;

    // Next-state logic, arbitration and request completion
    always_comb begin
        state_nxt_s = state_r;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        req_done_s  = 1'b0;
        if (usr_ack) begin
            req_resp_s = usr_err ? 2'b10 : 2'b00;
        end else begin
            req_resp_s = 2'b10;
        end
        case (state_r)
            IDLE: begin
                // On a tie the grant goes opposite to the previous one
                if (aw_full_r && w_full_r && (!ar_full_r || !last_wr_r)) begin
                    grant_wr_s  = 1'b1;
                    state_nxt_s = aw_in_s ? WR_REQ : WR_RESP;
                end else if (ar_full_r) begin
                    grant_rd_s  = 1'b1;
                    state_nxt_s = ar_in_s ? RD_REQ : RD_RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_REQ, RD_REQ: begin
                if (usr_ack || tmo_s) begin
                    req_done_s  = 1'b1;
                    state_nxt_s = (state_r == WR_REQ) ? WR_RESP : RD_RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_RESP;
                end
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == WR_REQ || state_r == RD_REQ) && state_nxt_s == state_r) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Channel buffers and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r      <= 1'b0;
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            ar_full_r <= 1'b0;
            last_wr_r <= 1'b0;
            aw_addr_r <= '0;
            ar_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
        end else begin
            en_r <= 1'b1;
            if (aw_hs_s) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= s_axil_awaddr;
            end else if (wr_free_s) begin
                aw_full_r <= 1'b0;
            end
            if (w_hs_s) begin
                w_full_r <= 1'b1;
                w_data_r <= s_axil_wdata;
                w_strb_r <= s_axil_wstrb;
            end else if (wr_free_s) begin
                w_full_r <= 1'b0;
            end
            if (ar_hs_s) begin
                ar_full_r <= 1'b1;
                ar_addr_r <= s_axil_araddr;
            end else if (rd_free_s) begin
                ar_full_r <= 1'b0;
            end
            if (grant_wr_s) begin
                last_wr_r <= 1'b1;
            end else if (grant_rd_s) begin
                last_wr_r <= 1'b0;
            end
        end
    end

    // User-side request strobes and held access fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_wen_r   <= 1'b0;
            usr_ren_r   <= 1'b0;
            usr_addr_r  <= '0;
            usr_wdata_r <= '0;
            usr_wstrb_r <= '0;
        end else begin
            usr_wen_r <= grant_wr_s & aw_in_s;
            usr_ren_r <= grant_rd_s & ar_in_s;
            if (grant_wr_s && aw_in_s) begin
                usr_addr_r  <= aw_addr_r - ADDR_BASE;
                usr_wdata_r <= w_data_r;
                usr_wstrb_r <= w_strb_r;
            end else if (grant_rd_s && ar_in_s) begin
                usr_addr_r <= ar_addr_r - ADDR_BASE;
            end else if (req_done_s) begin
                usr_addr_r  <= '0;
                usr_wdata_r <= '0;
                usr_wstrb_r <= '0;
            end
        end
    end

    // AXI-Lite B and R response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
            rvalid_r <= 1'b0;
            rresp_r  <= 2'b00;
            rdata_r  <= '0;
        end else begin
            if (grant_wr_s && !aw_in_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= 2'b11;
            end else if (req_done_s && state_r == WR_REQ) begin
                bvalid_r <= 1'b1;
                bresp_r  <= req_resp_s;
            end else if (wr_free_s) begin
                bvalid_r <= 1'b0;
            end
            if (grant_rd_s && !ar_in_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= 2'b11;
                rdata_r  <= '0;
            end else if (req_done_s && state_r == RD_REQ) begin
                rvalid_r <= 1'b1;
                rresp_r  <= req_resp_s;
                rdata_r  <= (usr_ack && !usr_err) ? usr_rdata : '0;
            end else if (rd_free_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_slave_arb.sv
// Scoreboard bench for axil_slave_arb: stimulus queues expected user accesses and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_slave_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata, usr_addr, usr_wdata, usr_rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb, usr_wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        usr_wen, usr_ren, usr_ack, usr_err;

    always #5 clk = ~clk;

    axil_slave_arb dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
        .usr_wen(usr_wen), .usr_ren(usr_ren), .usr_rdata(usr_rdata),
        .usr_ack(usr_ack), .usr_err(usr_err)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; int lat; } usr_t;
    typedef struct { int wt; bit err; logic [31:0] data; } dev_t;
    typedef struct { logic [1:0] resp; logic [31:0] data; int lat; } rsp_t;

    usr_t exp_usr_q[$];
    dev_t dev_q[$];
    rsp_t exp_b_q[$];
    rsp_t exp_r_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int aw_edge = 0, w_edge = 0, ar_edge = 0, b_first = 0, r_first = 0;
    bit prev_strobe = 0, b_seen = 0, r_seen = 0, b_stall = 0, r_stall = 0;
    logic [1:0] b_hold, r_hold;
    logic [31:0] rd_hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: handshake bookkeeping, strobe and response scoreboards
    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid && awready) aw_edge = cyc + 1;
            if (wvalid && wready)   w_edge  = cyc + 1;
            if (arvalid && arready) ar_edge = cyc + 1;
            if (usr_wen || usr_ren) begin
                usr_t u;
                chk("strobe_excl", 32'(usr_wen & usr_ren), 32'd0);
                chk("strobe_pulse", 32'(prev_strobe), 32'd0);
                if (exp_usr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe actual wen=%0d ren=%0d addr=%h expected no strobe", usr_wen, usr_ren, usr_addr);
                end else begin
                    u = exp_usr_q.pop_front();
                    chk("strobe_kind", 32'(usr_wen), 32'(u.wr));
                    chk("usr_addr", usr_addr, u.addr);
                    if (u.wr) begin
                        chk("usr_wdata", usr_wdata, u.data);
                        chk("usr_wstrb", 32'(usr_wstrb), 32'(u.strb));
                    end
                    if (u.lat >= 0)
                        chk("strobe_lat", 32'(cyc - (u.wr ? ((aw_edge > w_edge) ? aw_edge : w_edge) : ar_edge)), 32'(u.lat));
                end
            end
            prev_strobe = usr_wen | usr_ren;

            if (bvalid && !b_seen) begin b_seen = 1; b_first = cyc; end
            if (b_stall) begin
                chk("bvalid_hold", 32'(bvalid), 32'd1);
                chk("bresp_hold", 32'(bresp), 32'(b_hold));
            end
            b_stall = bvalid && !bready;
            b_hold  = bresp;
            if (bvalid && bready) begin
                rsp_t e;
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_b actual bresp=%0d expected no response", bresp);
                end else begin
                    e = exp_b_q.pop_front();
                    chk("bresp", 32'(bresp), 32'(e.resp));
                    if (e.lat >= 0)
                        chk("b_lat", 32'(b_first - ((aw_edge > w_edge) ? aw_edge : w_edge)), 32'(e.lat));
                end
                b_seen = 0;
            end

            if (rvalid && !r_seen) begin r_seen = 1; r_first = cyc; end
            if (r_stall) begin
                chk("rvalid_hold", 32'(rvalid), 32'd1);
                chk("rresp_hold", 32'(rresp), 32'(r_hold));
                chk("rdata_hold", rdata, rd_hold);
            end
            r_stall = rvalid && !rready;
            r_hold  = rresp;
            rd_hold = rdata;
            if (rvalid && rready) begin
                rsp_t e;
                if (exp_r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_r actual rresp=%0d rdata=%h expected no response", rresp, rdata);
                end else begin
                    e = exp_r_q.pop_front();
                    chk("rresp", 32'(rresp), 32'(e.resp));
                    chk("rdata", rdata, e.data);
                    if (e.lat >= 0) chk("r_lat", 32'(r_first - ar_edge), 32'(e.lat));
                end
                r_seen = 0;
            end
        end
    end

    // User register model: acks each strobe after the queued number of wait cycles
    initial begin
        usr_ack = 1'b0; usr_err = 1'b0; usr_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if ((usr_wen || usr_ren) && dev_q.size() != 0) begin
                dev_t d;
                d = dev_q.pop_front();
                for (int k = 0; k < d.wt; k++) begin @(posedge clk); #1; end
                usr_ack = 1'b1; usr_err = d.err; usr_rdata = d.data;
                @(posedge clk); #1;
                usr_ack = 1'b0; usr_err = 1'b0; usr_rdata = 32'h0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        @(posedge clk); #1;
        awaddr = a; awprot = 3'b010; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_accept", 32'(awready), 32'd1);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(posedge clk); #1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 50) begin @(negedge clk); n++; end
        chk("w_accept", 32'(wready), 32'd1);
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        @(posedge clk); #1;
        araddr = a; arprot = 3'b000; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int wt,
                          input bit err, input logic [1:0] resp, input int slat, input int blat);
        exp_usr_q.push_back('{wr: 1'b1, addr: a, data: d, strb: s, lat: slat});
        dev_q.push_back('{wt: wt, err: err, data: 32'h0});
        exp_b_q.push_back('{resp: resp, data: 32'h0, lat: blat});
    endtask

    task automatic exp_rd(input logic [31:0] a, input int wt, input bit err, input logic [31:0] d,
                          input logic [1:0] resp, input logic [31:0] expd, input int slat);
        exp_usr_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, strb: 4'h0, lat: slat});
        dev_q.push_back('{wt: wt, err: err, data: d});
        exp_r_q.push_back('{resp: resp, data: expd, lat: -1});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_usr_q.size() + exp_b_q.size() + exp_r_q.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("drain", 32'(exp_usr_q.size() + exp_b_q.size() + exp_r_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bready = 1'b1; rready = 1'b1;
        awaddr = 32'h0; awprot = 3'b000; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        araddr = 32'h0; arprot = 3'b000; arvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", 32'({usr_wen, usr_ren}), 32'd0);
        chk("rst_usr_addr", usr_addr, 32'd0);
        chk("rst_usr_wdata", usr_wdata, 32'd0);
        chk("rst_usr_wstrb", 32'(usr_wstrb), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("ready_second_cycle", 32'({awready, wready, arready}), 32'd7);

        // Zero-wait write
        exp_wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 2'b00, 1, 2);
        fork
            send_aw(32'h0000_0010);
            send_w(32'hDEADBEEF, 4'hF);
        join
        drain();

        // Read with three wait cycles
        exp_rd(32'h4, 3, 1'b0, 32'h12345678, 2'b00, 32'h12345678, 1);
        send_ar(32'h0000_0004);
        drain();

        // W five cycles ahead of AW
        exp_wr(32'h20, 32'hA5A5_0001, 4'h3, 0, 1'b0, 2'b00, 1, 2);
        send_w(32'hA5A5_0001, 4'h3);
        @(negedge clk);
        chk("wready_drop", 32'(wready), 32'd0);
        repeat (4) @(negedge clk);
        send_aw(32'h0000_0020);
        drain();

        // Out-of-range read: no strobe, DECERR, zero data
        exp_r_q.push_back('{resp: 2'b11, data: 32'h0, lat: -1});
        send_ar(32'h0000_2000);
        drain();

        // Simultaneous write and read, last grant was a read: W then R each round
        for (int i = 0; i < 4; i++) begin
            exp_wr(32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 0, 1'b0, 2'b00, -1, -1);
            exp_rd(32'h200 + 32'(i * 4), 0, 1'b0, 32'h5A00_0000 + 32'(i), 2'b00, 32'h5A00_0000 + 32'(i), -1);
            fork
                send_aw(32'h100 + 32'(i * 4));
                send_w(32'hC0DE_0000 + 32'(i), 4'hF);
                send_ar(32'h200 + 32'(i * 4));
            join
            drain();
        end

        // After a lone write, a tie goes to the read first
        exp_wr(32'h300, 32'h1111_2222, 4'hC, 0, 1'b0, 2'b00, 1, 2);
        fork
            send_aw(32'h300);
            send_w(32'h1111_2222, 4'hC);
        join
        drain();
        exp_rd(32'h400, 0, 1'b0, 32'h7777_8888, 2'b00, 32'h7777_8888, -1);
        exp_wr(32'h304, 32'h3333_4444, 4'h1, 0, 1'b0, 2'b00, -1, -1);
        fork
            send_aw(32'h304);
            send_w(32'h3333_4444, 4'h1);
            send_ar(32'h400);
        join
        drain();

        // Timeout: ack only after 20 cycles, which must be ignored
        exp_wr(32'h40, 32'hFEED_F00D, 4'hF, 20, 1'b0, 2'b10, 1, -1);
        fork
            send_aw(32'h40);
            send_w(32'hFEED_F00D, 4'hF);
        join
        drain();
        repeat (15) @(negedge clk);

        // Read acked with error
        exp_rd(32'h8, 1, 1'b1, 32'hFFFF_FFFF, 2'b10, 32'h0, 1);
        send_ar(32'h8);
        drain();

        // bready held low for ten cycles with an error write response pending
        @(posedge clk); #1 bready = 1'b0;
        exp_wr(32'h44, 32'h0BAD_CAFE, 4'hF, 0, 1'b1, 2'b10, 1, 2);
        fork
            send_aw(32'h44);
            send_w(32'h0BAD_CAFE, 4'hF);
        join
        begin
            int n = 0;
            while (!bvalid && n < 20) begin @(negedge clk); n++; end
            chk("bvalid_seen", 32'(bvalid), 32'd1);
        end
        repeat (10) @(posedge clk);
        #1 bready = 1'b1;
        drain();

        chk("idle_usr_addr", usr_addr, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
